// File: rtl/bram_add_seq.sv
// bram_add_seq: walks an address window over two BRAMs, adds word pairs, streams sums.
// Optional SATURATE_EN clamps each sum to DATA_W bits.
module bram_add_seq #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              ena1,
  output logic              ena2,
  output logic [ADDR_W-1:0] addra1,
  output logic [ADDR_W-1:0] addra2,
  input  logic [DATA_W-1:0] douta1,
  input  logic [DATA_W-1:0] douta2,
  output logic [DATA_W:0]   sum_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAP,
    OUT,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [1:0]        cap_cnt;
  logic              cap_last;
  logic              last_pair;
  logic [DATA_W:0]   sum_raw;
  logic [DATA_W:0]   sum_nxt;
  logic [DATA_W:0]   sum_q;

  // Truncation to ADDR_W makes the window wrap at the top of the BRAM
  assign rd_addr   = base_q + idx[ADDR_W-1:0];
  assign idx_inc   = idx + {{ADDR_W{1'b0}}, 1'b1};
  assign last_pair = (idx_inc == len_q);
  assign cap_last  = (cap_cnt == 2'(READ_LAT - 1));
  assign sum_raw   = {1'b0, douta1} + {1'b0, douta2};

`ifdef SATURATE_EN
  assign sum_nxt = sum_raw[DATA_W] ? {1'b0, {DATA_W{1'b1}}} : sum_raw;
`else
  assign sum_nxt = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt = (len == '0) ? DONE : READ;
        end
      end
      READ: nxt = CAP;
      CAP: begin
        if (cap_last) begin
          nxt = OUT;
        end
      end
      OUT: begin
        if (sum_ready) begin
          nxt = last_pair ? DONE : READ;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      len_q   <= '0;
      idx     <= '0;
      addr_q  <= '0;
      cap_cnt <= '0;
      sum_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= len;
            idx    <= '0;
          end
        end
        READ: begin
          addr_q  <= rd_addr;
          cap_cnt <= '0;
        end
        CAP: begin
          cap_cnt <= cap_cnt + 2'd1;
          if (cap_last) begin
            sum_q <= sum_nxt;
          end
        end
        OUT: begin
          if (sum_ready) begin
            idx <= idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ena1      = (state == READ);
    ena2      = (state == READ);
    addra1    = (state == READ) ? rd_addr : addr_q;
    addra2    = (state == READ) ? rd_addr : addr_q;
    sum_valid = (state == OUT);
    busy      = (state != IDLE);
    done      = (state == DONE);
    sum_data  = sum_q;
  end

endmodule

// File: tb/tb_bram_add_seq.sv
// tb_bram_add_seq: randomized runs of bram_add_seq against a window-sum model.
// Behavioural BRAMs with one-cycle read latency feed the design.
module tb_bram_add_seq;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          ena1, ena2;
  logic [AW-1:0] addra1, addra2;
  logic [DW-1:0] douta1 = '0;
  logic [DW-1:0] douta2 = '0;
  logic [DW:0]   sum_data;
  logic          sum_valid, sum_ready, busy, done;
  logic          fix_rdy = 1'b1;
  logic          rand_en = 1'b0;
  logic          rnd_bit = 1'b0;

  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_q[$];
  logic [DW:0] got_q[$];
  int rise_q[$];
  int hs_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int port_mis = 0;
  logic prev_sv = 1'b0;

  assign sum_ready = rand_en ? rnd_bit : fix_rdy;

  bram_add_seq #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .len(len),
    .ena1(ena1), .ena2(ena2),
    .addra1(addra1), .addra2(addra2),
    .douta1(douta1), .douta2(douta2),
    .sum_data(sum_data), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ena1) douta1 <= mem1[addra1];
    if (ena2) douta2 <= mem2[addra2];
    rnd_bit <= 1'($urandom);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ena1) rd_q.push_back(int'(addra1));
    if (ena1 !== ena2 || addra1 !== addra2) port_mis++;
    if (sum_valid && !prev_sv) rise_q.push_back(cyc);
    prev_sv = sum_valid;
    if (sum_valid && sum_ready) begin
      got_q.push_back(sum_data);
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW:0] ref_sum(input int a);
    int s;
    s = int'(mem1[a % 256]) + int'(mem2[a % 256]);
`ifdef SATURATE_EN
    if (s > 65535) s = 65535;
`endif
    return (DW+1)'(s);
  endfunction

  task automatic clear_logs();
    rd_q.delete();
    got_q.delete();
    rise_q.delete();
    done_cnt = 0;
    port_mis = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      mem1[i] = DW'($urandom);
      mem2[i] = DW'($urandom);
    end
  endtask

  task automatic start_run(input int b, input int l, output int acc);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    len = (AW+1)'(l);
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ena1, ena2, addra1, addra2, sum_data, sum_valid, done} !== '0)
      begin bad++; $display("FAIL reset_outs got=%0h exp=0",
        {ena1, ena2, addra1, addra2, sum_data, sum_valid, done}); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    clear_logs();
    repeat (10) @(negedge clk);
    total++;
    if (rd_q.size() != 0 || got_q.size() != 0 || rise_q.size() != 0)
      begin bad++; $display("FAIL idle_quiet reads=%0d sums=%0d exp=0",
        rd_q.size(), rise_q.size()); end
  endtask

  task automatic test_basic();
    int acc;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = DW'(i);
      mem2[i] = DW'(100 + i);
    end
    clear_logs();
    fix_rdy = 1'b1;
    start_run(4, 3, acc);
    wait_done(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout got=nodone exp=done"); end
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++;
      if (got_q[i] !== 17'(108 + 2*i))
        begin bad++; $display("FAIL basic_sum%0d got=%0d exp=%0d", i, got_q[i], 108 + 2*i); end
    end
    total++;
    if (rd_q.size() != 3) begin bad++; $display("FAIL basic_reads got=%0d exp=3", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 3; i++) begin
      total++;
      if (rd_q[i] != 4 + i) begin bad++; $display("FAIL basic_addr%0d got=%0d exp=%0d", i, rd_q[i], 4 + i); end
    end
    total++;
    if (rise_q.size() < 2) begin bad++; $display("FAIL basic_rises got=%0d exp=3", rise_q.size()); end
    else begin
      if (rise_q[0] - acc + 1 != RL + 2)
        begin bad++; $display("FAIL first_latency got=%0d exp=%0d", rise_q[0] - acc + 1, RL + 2); end
      total++;
      if (rise_q[1] - rise_q[0] != RL + 2)
        begin bad++; $display("FAIL throughput got=%0d exp=%0d", rise_q[1] - rise_q[0], RL + 2); end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    total++;
    if (done_cyc != hs_cyc + 1) begin bad++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc, hs_cyc + 1); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_fall got=%b exp=0", busy); end
    total++;
    if (port_mis != 0) begin bad++; $display("FAIL port_match got=%0d exp=0", port_mis); end
  endtask

  task automatic test_wrap_carry();
    int acc;
    bit ok;
    logic [DW:0] exp_v;
`ifdef SATURATE_EN
    exp_v = 17'h0FFFF;
`else
    exp_v = 17'h1FFFE;
`endif
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'hFFFF;
      mem2[i] = 16'hFFFF;
    end
    clear_logs();
    start_run(254, 4, acc);
    wait_done(100, ok);
    total++;
    if (!ok || got_q.size() != 4 || rd_q.size() != 4)
      begin bad++; $display("FAIL wrap_count got=%0d/%0d exp=4", got_q.size(), rd_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++;
      if (got_q[i] !== exp_v) begin bad++; $display("FAIL wrap_sum%0d got=%0h exp=%0h", i, got_q[i], exp_v); end
    end
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      total++;
      if (rd_q[i] != (254 + i) % 256)
        begin bad++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, rd_q[i], (254 + i) % 256); end
    end
  endtask

  task automatic test_backpressure();
    int acc, b;
    bit ok, stable;
    logic [DW:0] v;
    fill_random();
    b = $urandom_range(0, 255);
    clear_logs();
    fix_rdy = 1'b0;
    start_run(b, 2, acc);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sum_valid) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL bp_valid got=0 exp=1"); end
    v = sum_data;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (sum_data !== v || sum_valid !== 1'b1 || ena1 !== 1'b0) stable = 1'b0;
    end
    total++;
    if (!stable) begin bad++; $display("FAIL bp_stable got=0 exp=1"); end
    total++;
    if (rd_q.size() != 1) begin bad++; $display("FAIL bp_reads got=%0d exp=1", rd_q.size()); end
    total++;
    if (v !== ref_sum(b)) begin bad++; $display("FAIL bp_sum0 got=%0h exp=%0h", v, ref_sum(b)); end
    fix_rdy = 1'b1;
    wait_done(50, ok);
    total++;
    if (!ok || got_q.size() != 2 || rd_q.size() != 2)
      begin bad++; $display("FAIL bp_count got=%0d exp=2", got_q.size()); end
    else begin
      total++;
      if (got_q[1] !== ref_sum(b + 1))
        begin bad++; $display("FAIL bp_sum1 got=%0h exp=%0h", got_q[1], ref_sum(b + 1)); end
      total++;
      if (rd_q[1] != (b + 1) % 256)
        begin bad++; $display("FAIL bp_addr1 got=%0d exp=%0d", rd_q[1], (b + 1) % 256); end
    end
  endtask

  task automatic test_len0();
    int acc;
    bit ok;
    clear_logs();
    start_run(7, 0, acc);
    wait_done(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL len0_done got=nodone exp=done"); end
    total++;
    if (done_cyc - acc + 1 != 1) begin bad++; $display("FAIL len0_timing got=%0d exp=1", done_cyc - acc + 1); end
    total++;
    if (rd_q.size() != 0 || got_q.size() != 0)
      begin bad++; $display("FAIL len0_quiet got=%0d exp=0", rd_q.size() + got_q.size()); end
  endtask

  task automatic check_run(input int b, input int l, input string nm);
    int errs;
    errs = 0;
    total++;
    if (got_q.size() != l || rd_q.size() != l)
      begin bad++; $display("FAIL %s_count got=%0d/%0d exp=%0d", nm, got_q.size(), rd_q.size(), l); end
    for (int i = 0; i < got_q.size() && i < l; i++)
      if (got_q[i] !== ref_sum(b + i)) begin
        errs++;
        if (errs < 4) $display("FAIL %s_sum%0d got=%0h exp=%0h", nm, i, got_q[i], ref_sum(b + i));
      end
    for (int i = 0; i < rd_q.size() && i < l; i++)
      if (rd_q[i] != (b + i) % 256) begin
        errs++;
        if (errs < 4) $display("FAIL %s_addr%0d got=%0d exp=%0d", nm, i, rd_q[i], (b + i) % 256);
      end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic test_len256_midstart();
    int acc, b;
    bit ok;
    fill_random();
    b = $urandom_range(0, 255);
    clear_logs();
    rand_en = 1'b1;
    start_run(b, 256, acc);
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b + 77);
    len = 9'd5;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5000, ok);
    rand_en = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL len256_timeout got=nodone exp=done"); end
    check_run(b, 256, "len256");
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL len256_done got=%0d exp=1", done_cnt); end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL len256_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int acc, b;
    bit ok;
    fill_random();
    b = $urandom_range(0, 255);
    clear_logs();
    fix_rdy = 1'b1;
    start_run(b, 3, acc);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (got_q.size() == 1) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 10 && ok; i++) begin
      @(negedge clk);
      if (ena1) break;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (!ok || {ena1, ena2, addra1, addra2, sum_data, sum_valid, busy, done} !== '0)
      begin bad++; $display("FAIL midreset_outs got=%0h exp=0",
        {ena1, ena2, addra1, addra2, sum_data, sum_valid, busy, done}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() != 0 || rd_q.size() != 0 || busy !== 1'b0)
      begin bad++; $display("FAIL midreset_quiet got=%0d exp=0", got_q.size() + rd_q.size()); end
    start_run(0, 1, acc);
    wait_done(50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midreset_run got=nodone exp=done"); end
    check_run(0, 1, "midreset");
  endtask

  task automatic test_random();
    int acc, b, l;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      b = $urandom_range(0, 255);
      l = $urandom_range(1, 20);
      clear_logs();
      rand_en = 1'b1;
      start_run(b, l, acc);
      wait_done(500, ok);
      rand_en = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=nodone exp=done", r); end
      check_run(b, l, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_carry();
    test_backpressure();
    test_len0();
    test_len256_midstart();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/bram_add_seq.md
# bram_add_seq

Read-side sequencer and adder that sits directly downstream of the two 256x16 operand BRAMs. On a start command it walks a contiguous address window, issues synchronous reads to both BRAM ports in lockstep, adds each pair of words, and presents each sum on a valid/ready output stream. It drives the BRAM enable and address inputs only; the BRAM write ports belong to the loader and are outside this block.

## Interface
- ADDR_W, 8, BRAM address width (depth 2^ADDR_W)
- DATA_W, 16, BRAM word width
- READ_LAT, 1, BRAM read latency in cycles from the ena/addr sampling edge to valid douta; legal values 1 and 2
- clk  input  1  single clock; all logic is rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request, sampled only in IDLE
- base_addr  input  ADDR_W  first address of the window, latched on accepted start
- len  input  ADDR_W+1  number of word pairs, 0..2^ADDR_W, latched on accepted start
- ena1, ena2  output  1  BRAM port enables (identical)
- addra1, addra2  output  ADDR_W  BRAM read addresses (identical)
- douta1, douta2  input  DATA_W  BRAM read data
- sum_data  output  DATA_W+1  sum of the current pair
- sum_valid  output  1  sum_data valid
- sum_ready  input  1  downstream accepts sum_data
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of run

## Operation
- States: IDLE, READ, CAP, OUT, DONE.
- IDLE: start=1 latches base_addr and len, clears index; len=0 -> DONE, else -> READ. start is ignored in every other state.
- READ (1 cycle): ena1=ena2=1, addra = base + index, modulo 2^ADDR_W (the window wraps 255 -> 0 for ADDR_W=8). -> CAP.
- CAP (READ_LAT cycles, internal counter): ena low. On the last CAP edge, sum_data <= douta1 + douta2 at DATA_W+1 bits, zero-extended, carry in the MSB. -> OUT.
- OUT: sum_valid=1, sum_data held stable until sum_valid && sum_ready on a rising edge. On handshake: index+1; if index+1 == len -> DONE, else -> READ.
- DONE (1 cycle): done=1. -> IDLE.
- ena1/ena2 high only in READ. addra holds its last value outside READ.
- Reset (any time, including mid-run): state IDLE; ena1, ena2, sum_valid, busy, done = 0; addra1, addra2, sum_data = 0; index and latched len cleared. No partial sum is emitted after reset release.

## Timing
- First sum_valid rises READ_LAT+2 edges after the edge that accepts start.
- Each further sum_valid rises READ_LAT+2 edges after the previous handshake edge.
- Per-pair throughput with sum_ready held high: one sum every READ_LAT+2 cycles.
- done rises 1 edge after the final handshake edge; busy falls 1 edge after done rises.
- With len=0, done rises 1 edge after start is accepted and no BRAM read is issued.
- A start held high through a run is accepted again in the IDLE cycle after DONE.
- sum_ready low stalls OUT indefinitely. No read is issued while stalled.

## Configuration
- SATURATE_EN defined: a sum above 2^DATA_W-1 is clamped to 2^DATA_W-1, and sum_data[DATA_W] is always 0.
- SATURATE_EN undefined: full-width sum with the carry in sum_data[DATA_W]. This is the default.

## Test plan
- Reset/idle: hold rst_n=0 -> all outputs 0, busy=0. Release and wait 10 cycles with start=0 -> no ena, no sum_valid.
- Basic run: BRAM1[i]=i, BRAM2[i]=100+i. start with base=4, len=3, sum_ready=1 -> sums 108, 110, 112. sum_valid rises 3 edges after start; done pulses once; exactly 3 reads at addresses 4, 5, 6.
- Wrap and carry: base=254, len=4, every word 0xFFFF -> addresses 254, 255, 0, 1; each sum_data=0x1FFFE. With SATURATE_EN defined, each sum_data=0x0FFFF.
- Backpressure: len=2, sum_ready low for 5 cycles while the first sum is valid -> sum_data stable, ena low throughout the stall, second read only after the handshake.
- Corner cases: len=0 -> done one edge after start, no ena. len=256 -> 256 sums, done once. start pulsed mid-run -> ignored.
- Reset mid-run: assert rst_n=0 during CAP of the 2nd pair -> outputs 0 immediately. After release, a new run with base=0, len=1 gives the correct single sum.
